cpu_reg_file: RTL and testbench
===============================

Name: cpu_reg_file

Overview:
Parametrised multi-port register file for the SM83 core. It holds the 8-bit registers, indexed by register_n_t (B..F), and the 16-bit PC. It provides N_RD asynchronous 8-bit read ports, N_WR 8-bit write ports, a 16-bit pair address output and an increment/decrement unit (IDU) with write-back. It also handles WZ-copy ops and ALU flag updates with a fixed per-register write priority. It sits between the decoder/control FSM, the ALU and the bus unit, and replaces the fixed 2R/1W register file.

Parameters:
N_RD, 2, number of 8-bit read ports (1..4)
N_WR, 2, number of 8-bit write ports (1..3)
SP_RESET, 16'hFFFE, SP value on reset
PC_RESET, 16'h0000, PC value on reset
LDH_BASE, 8'hFF, high byte of the LDH_Z/LDH_C address

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_sel  in  4*N_RD  register_n_t select per read port
rd_data  out  8*N_RD  read data per port, combinational
wr_en  in  N_WR  8-bit write enable per port
wr_sel  in  4*N_WR  register_n_t target per write port
wr_data  in  8*N_WR  write data per port
addr_sel  in  3  register_nn_t select for addr_out and IDU source
addr_out  out  16  selected pair value, combinational
idu_en  in  1  write back addr_out±1 to pair addr_sel
idu_dec  in  1  0 = +1, 1 = -1
pair_wr_en  in  1  16-bit pair write
pair_wr_sel  in  3  register_nn_t target (BC, DE, HL, SP, PC, WZ only)
pair_wr_data  in  16  pair write data
copy_op  in  3  copy_wz_to_rr_op_t
flags_wr_en  in  1  update F[7:4] from flags_in
flags_in  in  4  {Z,N,H,C}
pc_out  out  16  current PC
sp_out  out  16  current SP

Behaviour:
- Reset (async, any time, including mid-instruction): B..L, Z, A, W, F = 0; {SPH,SPL} = SP_RESET; PC = PC_RESET. rd_data, addr_out, pc_out and sp_out follow combinationally (e.g. addr_sel=SP gives 16'hFFFE).
- Storage: twelve 8-bit registers at register_n_t codes 0..11, plus 16-bit PC. Codes 12..15 read 8'h00; writes to them are ignored.
- F[3:0] is hard-wired 0 on every write path and always reads 0.
- Reads are asynchronous with no write bypass: a write in cycle N is visible on reads in cycle N+1.
- Pair mapping for reads (addr_out): BC={B,C}, DE={D,E}, HL={H,L}, SP={SPH,SPL}, PC=PC, WZ={W,Z}, LDH_Z={LDH_BASE,Z}, LDH_C={LDH_BASE,C}.
- IDU:
  - When idu_en=1, the next value of pair addr_sel is addr_out+1, or addr_out-1 if idu_dec=1, modulo 2^16.
  - FFFF+1 wraps to 0000; 0000-1 wraps to FFFF.
  - When addr_sel is LDH_Z or LDH_C, the write-back is suppressed; Z and C are unchanged.
- pair_wr: when pair_wr_en=1, loads pair_wr_data into the selected pair. pair_wr_sel of LDH_Z or LDH_C is ignored.
- copy_op: copies {W,Z} into BC, DE, HL or SP, or into {A,F} with F=Z&8'hF0. Codes 010 and 011 are no-ops.
- Write priority per 8-bit register per cycle, highest first:
  1. copy_op
  2. pair_wr
  3. IDU write-back
  4. 8-bit write ports (highest port index wins)
  5. flags_wr (F only)
- Conflict resolution is per byte. Writers targeting different registers in the same cycle all take effect.
- PC is written only by pair_wr and the IDU, with pair_wr taking priority. The 8-bit ports cannot write PC.
- No internal state machine beyond storage. Single-cycle update, zero-latency read.

Test Plan:
- Assert rst mid-cycle after loading BC=1234 → B=C=00 immediately; sp_out=FFFE, pc_out=0000 before the next clk edge.
- wr_en[0] writes A=5A at edge N; rd_sel=A → rd_data shows old value during cycle N and 5A after edge N.
- addr_sel=HL=FFFF with idu_en=1, idu_dec=0 → HL=0000. addr_sel=SP=0000 with idu_dec=1 → SP=FFFF. addr_sel=LDH_C with C=10 → addr_out=FF10, and idu_en leaves C=10.
- Same cycle: wr port0 H=11, wr port1 H=22, pair_wr HL=ABCD → HL=ABCD. Without pair_wr → H=22.
- WZ=12FF with copy_op=COPY_WZ_TO_AF and flags_wr_en=1, flags_in=0 → A=12, F=F0. Then a write of F=FF on port 0 → F reads F0.
- pair_wr PC=0150 and idu_en on addr_sel=PC (PC=0100) in the same cycle → PC=0150. Next cycle idu_en only → PC=0151.

Source files
------------

// File: rtl/cpu_reg_file.sv
// rtl/cpu_reg_file.sv - SM83 multi-port register file with pair addressing, IDU and WZ copy
module cpu_reg_file #(
   parameter int          N_RD     = 2,
   parameter int          N_WR     = 2,
   parameter logic [15:0] SP_RESET = 16'hFFFE,
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [7:0]  LDH_BASE = 8'hFF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*N_RD-1:0]   rd_sel,
   output logic [8*N_RD-1:0]   rd_data,
   input  logic [N_WR-1:0]     wr_en,
   input  logic [4*N_WR-1:0]   wr_sel,
   input  logic [8*N_WR-1:0]   wr_data,
   input  logic [2:0]          addr_sel,
   output logic [15:0]         addr_out,
   input  logic                idu_en,
   input  logic                idu_dec,
   input  logic                pair_wr_en,
   input  logic [2:0]          pair_wr_sel,
   input  logic [15:0]         pair_wr_data,
   input  logic [2:0]          copy_op,
   input  logic                flags_wr_en,
   input  logic [3:0]          flags_in,
   output logic [15:0]         pc_out,
   output logic [15:0]         sp_out
);

   // 8-bit register codes; 12..15 are unbacked and read as zero
   typedef enum logic [3:0] {
      REG_B   = 4'd0,
      REG_C   = 4'd1,
      REG_D   = 4'd2,
      REG_E   = 4'd3,
      REG_H   = 4'd4,
      REG_L   = 4'd5,
      REG_Z   = 4'd6,
      REG_A   = 4'd7,
      REG_SPH = 4'd8,
      REG_SPL = 4'd9,
      REG_W   = 4'd10,
      REG_F   = 4'd11
   } register_n_t;

   // 16-bit pair codes used by addr_sel and pair_wr_sel
   typedef enum logic [2:0] {
      RR_BC    = 3'd0,
      RR_DE    = 3'd1,
      RR_HL    = 3'd2,
      RR_SP    = 3'd3,
      RR_PC    = 3'd4,
      RR_WZ    = 3'd5,
      RR_LDH_Z = 3'd6,
      RR_LDH_C = 3'd7
   } register_nn_t;

   // WZ copy targets; bit 2 set selects a pair from bits [1:0]
   typedef enum logic [2:0] {
      COPY_NONE     = 3'd0,
      COPY_WZ_TO_AF = 3'd1,
      COPY_NOP_2    = 3'd2,
      COPY_NOP_3    = 3'd3,
      COPY_WZ_TO_BC = 3'd4,
      COPY_WZ_TO_DE = 3'd5,
      COPY_WZ_TO_HL = 3'd6,
      COPY_WZ_TO_SP = 3'd7
   } copy_wz_to_rr_op_t;

   localparam int         NREG      = 12;
   localparam logic [3:0] NREG_CODE = 4'd12;

   logic [7:0]  regs_q [NREG];
   logic [7:0]  regs_d [NREG];
   logic [15:0] pc_q;
   logic [15:0] pc_d;
   logic [15:0] idu_val;
   logic        idu_wb;
   logic        pair_wb;

   // High byte register of a byte-backed pair (BC, DE, HL, SP, WZ)
   function automatic logic [3:0] pair_hi(input logic [2:0] p);
      case (p)
         RR_BC:   pair_hi = REG_B;
         RR_DE:   pair_hi = REG_D;
         RR_HL:   pair_hi = REG_H;
         RR_SP:   pair_hi = REG_SPH;
         default: pair_hi = REG_W;
      endcase
   endfunction

   // Low byte register of a byte-backed pair (BC, DE, HL, SP, WZ)
   function automatic logic [3:0] pair_lo(input logic [2:0] p);
      case (p)
         RR_BC:   pair_lo = REG_C;
         RR_DE:   pair_lo = REG_E;
         RR_HL:   pair_lo = REG_L;
         RR_SP:   pair_lo = REG_SPL;
         default: pair_lo = REG_Z;
      endcase
   endfunction

   // Pair/address mux; LDH forms place the fixed high page over Z or C
   always_comb begin
      addr_out = 16'h0000;
      case (addr_sel)
         RR_BC:    addr_out = {regs_q[REG_B], regs_q[REG_C]};
         RR_DE:    addr_out = {regs_q[REG_D], regs_q[REG_E]};
         RR_HL:    addr_out = {regs_q[REG_H], regs_q[REG_L]};
         RR_SP:    addr_out = {regs_q[REG_SPH], regs_q[REG_SPL]};
         RR_PC:    addr_out = pc_q;
         RR_WZ:    addr_out = {regs_q[REG_W], regs_q[REG_Z]};
         RR_LDH_Z: addr_out = {LDH_BASE, regs_q[REG_Z]};
         default:  addr_out = {LDH_BASE, regs_q[REG_C]};
      endcase
   end

   assign idu_val = idu_dec ? (addr_out - 16'd1) : (addr_out + 16'd1);
   // LDH addresses are not real pairs, so they never take a write-back
   assign idu_wb  = idu_en && (addr_sel != RR_LDH_Z) && (addr_sel != RR_LDH_C);
   assign pair_wb = pair_wr_en && (pair_wr_sel != RR_LDH_Z) && (pair_wr_sel != RR_LDH_C);

   // Next state: writers applied lowest priority first so higher ones overwrite per byte
   always_comb begin
      regs_d = regs_q;
      pc_d   = pc_q;

      if (flags_wr_en) begin
         regs_d[REG_F] = {flags_in, 4'h0};
      end

      for (int p = 0; p < N_WR; p++) begin
         if (wr_en[p] && (wr_sel[4*p +: 4] < NREG_CODE)) begin
            regs_d[wr_sel[4*p +: 4]] = wr_data[8*p +: 8];
         end
      end

      if (idu_wb) begin
         if (addr_sel == RR_PC) begin
            pc_d = idu_val;
         end else begin
            regs_d[pair_hi(addr_sel)] = idu_val[15:8];
            regs_d[pair_lo(addr_sel)] = idu_val[7:0];
         end
      end

      if (pair_wb) begin
         if (pair_wr_sel == RR_PC) begin
            pc_d = pair_wr_data;
         end else begin
            regs_d[pair_hi(pair_wr_sel)] = pair_wr_data[15:8];
            regs_d[pair_lo(pair_wr_sel)] = pair_wr_data[7:0];
         end
      end

      case (copy_op)
         COPY_WZ_TO_AF: begin
            regs_d[REG_A] = regs_q[REG_W];
            regs_d[REG_F] = regs_q[REG_Z] & 8'hF0;
         end
         COPY_WZ_TO_BC, COPY_WZ_TO_DE, COPY_WZ_TO_HL, COPY_WZ_TO_SP: begin
            regs_d[pair_hi({1'b0, copy_op[1:0]})] = regs_q[REG_W];
            regs_d[pair_lo({1'b0, copy_op[1:0]})] = regs_q[REG_Z];
         end
         default: ;
      endcase

      // Low flag nibble does not exist in hardware
      regs_d[REG_F][3:0] = 4'h0;
   end

   // Storage update with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
         regs_q[REG_SPH] <= SP_RESET[15:8];
         regs_q[REG_SPL] <= SP_RESET[7:0];
         pc_q            <= PC_RESET;
      end else begin
         regs_q <= regs_d;
         pc_q   <= pc_d;
      end
   end

   // Asynchronous read ports, no bypass of same-cycle writes
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < N_RD; p++) begin
         if (rd_sel[4*p +: 4] < NREG_CODE) begin
            rd_data[8*p +: 8] = regs_q[rd_sel[4*p +: 4]];
         end
      end
   end

   assign pc_out = pc_q;
   assign sp_out = {regs_q[REG_SPH], regs_q[REG_SPL]};

endmodule

// File: tb/tb_cpu_reg_file.sv
// tb/tb_cpu_reg_file.sv - scoreboard bench for cpu_reg_file with randomized stimulus
module tb_cpu_reg_file;
   localparam int N_RD = 2;
   localparam int N_WR = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rd_sel;
   logic [15:0] rd_data;
   logic [1:0]  wr_en;
   logic [7:0]  wr_sel;
   logic [15:0] wr_data;
   logic [2:0]  addr_sel;
   logic [15:0] addr_out;
   logic        idu_en;
   logic        idu_dec;
   logic        pair_wr_en;
   logic [2:0]  pair_wr_sel;
   logic [15:0] pair_wr_data;
   logic [2:0]  copy_op;
   logic        flags_wr_en;
   logic [3:0]  flags_in;
   logic [15:0] pc_out;
   logic [15:0] sp_out;

   cpu_reg_file #(
      .N_RD(N_RD), .N_WR(N_WR),
      .SP_RESET(16'hFFFE), .PC_RESET(16'h0000), .LDH_BASE(8'hFF)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_sel(rd_sel), .rd_data(rd_data),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .addr_sel(addr_sel), .addr_out(addr_out),
      .idu_en(idu_en), .idu_dec(idu_dec),
      .pair_wr_en(pair_wr_en), .pair_wr_sel(pair_wr_sel), .pair_wr_data(pair_wr_data),
      .copy_op(copy_op),
      .flags_wr_en(flags_wr_en), .flags_in(flags_in),
      .pc_out(pc_out), .sp_out(sp_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void check(string name, logic [15:0] act, logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   // Reference model: register names B C D E H L Z A SPH SPL W F at 0..11
   logic [7:0]  m [12];
   logic [15:0] mpc;
   logic [7:0]  nxt [12];
   bit          cl [12];
   int          hi_of [6] = '{0, 2, 4, 8, -1, 10};
   int          lo_of [6] = '{1, 3, 5, 9, -1, 6};

   typedef struct packed {
      logic [15:0] rd;
      logic [15:0] addr;
      logic [15:0] pc;
      logic [15:0] sp;
   } exp_t;
   exp_t exp_q [$];

   task model_reset();
      for (int i = 0; i < 12; i++) m[i] = 8'h00;
      m[8] = 8'hFF;
      m[9] = 8'hFE;
      mpc  = 16'h0000;
   endtask

   function automatic logic [15:0] mpair(int p);
      case (p)
         0: return {m[0], m[1]};
         1: return {m[2], m[3]};
         2: return {m[4], m[5]};
         3: return {m[8], m[9]};
         4: return mpc;
         5: return {m[10], m[6]};
         6: return {8'hFF, m[6]};
         default: return {8'hFF, m[1]};
      endcase
   endfunction

   // A byte is owned by the first (highest priority) writer that claims it
   function automatic void claim(int idx, logic [7:0] v);
      if (idx >= 0 && idx < 12 && !cl[idx]) begin
         nxt[idx] = v;
         cl[idx]  = 1'b1;
      end
   endfunction

   function automatic void claim_pair(int p, logic [15:0] v);
      claim(hi_of[p], v[15:8]);
      claim(lo_of[p], v[7:0]);
   endfunction

   task model_apply();
      logic [15:0] pcn;
      bit          pcl;
      int          t;
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 12; i++) begin
            nxt[i] = m[i];
            cl[i]  = 1'b0;
         end
         pcn = mpc;
         pcl = 1'b0;
         if (copy_op == 3'd1) begin
            claim(7, m[10]);
            claim(11, m[6] & 8'hF0);
         end else if (copy_op >= 3'd4) begin
            claim_pair(int'(copy_op) - 4, {m[10], m[6]});
         end
         if (pair_wr_en && pair_wr_sel < 3'd6) begin
            if (pair_wr_sel == 3'd4) begin
               pcn = pair_wr_data;
               pcl = 1'b1;
            end else begin
               claim_pair(int'(pair_wr_sel), pair_wr_data);
            end
         end
         if (idu_en && addr_sel < 3'd6) begin
            t = int'(mpair(int'(addr_sel))) + (idu_dec ? -1 : 1);
            t = (t + 65536) % 65536;
            if (addr_sel == 3'd4) begin
               if (!pcl) pcn = t[15:0];
            end else begin
               claim_pair(int'(addr_sel), t[15:0]);
            end
         end
         for (int p = N_WR - 1; p >= 0; p--) begin
            if (wr_en[p]) claim(int'(wr_sel[4*p +: 4]), wr_data[8*p +: 8]);
         end
         if (flags_wr_en) claim(11, {flags_in, 4'h0});
         nxt[11][3:0] = 4'h0;
         for (int i = 0; i < 12; i++) m[i] = nxt[i];
         mpc = pcn;
      end
   endtask

   task push_expected();
      exp_t e;
      logic [3:0] s;
      for (int p = 0; p < N_RD; p++) begin
         s = rd_sel[4*p +: 4];
         e.rd[8*p +: 8] = (s < 4'd12) ? m[s] : 8'h00;
      end
      e.addr = mpair(int'(addr_sel));
      e.pc   = mpc;
      e.sp   = {m[8], m[9]};
      exp_q.push_back(e);
   endtask

   task idle();
      rst          = 1'b0;
      wr_en        = 2'b00;
      wr_sel       = 8'h00;
      wr_data      = 16'h0000;
      addr_sel     = 3'd0;
      idu_en       = 1'b0;
      idu_dec      = 1'b0;
      pair_wr_en   = 1'b0;
      pair_wr_sel  = 3'd0;
      pair_wr_data = 16'h0000;
      copy_op      = 3'd0;
      flags_wr_en  = 1'b0;
      flags_in     = 4'h0;
   endtask

   task cycle();
      model_apply();
      @(posedge clk);
      #1;
      idle();
   endtask

   task rd_reg(input logic [3:0] idx, output logic [7:0] v);
      rd_sel[3:0] = idx;
      #1;
      v = rd_data[7:0];
   endtask

   task pair_write(input logic [2:0] sel, input logic [15:0] d);
      pair_wr_en   = 1'b1;
      pair_wr_sel  = sel;
      pair_wr_data = d;
   endtask

   // Monitor: compare DUT outputs to the queued expectation mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("rd_data", rd_data, e.rd);
         check("addr_out", addr_out, e.addr);
         check("pc_out", pc_out, e.pc);
         check("sp_out", sp_out, e.sp);
      end
   end

   initial begin
      logic [7:0] v;
      idle();
      rd_sel = 8'h00;
      rst = 1'b1;
      model_reset();
      addr_sel = 3'd3;
      #1;
      check("reset_sp_addr", addr_out, 16'hFFFE);
      check("reset_sp_out", sp_out, 16'hFFFE);
      check("reset_pc_out", pc_out, 16'h0000);
      @(posedge clk);
      #1;
      idle();

      // Asynchronous reset mid-cycle after loading BC and PC
      pair_write(3'd4, 16'h0100);
      cycle();
      pair_write(3'd0, 16'h1234);
      cycle();
      rd_sel = {4'd1, 4'd0};
      #1;
      check("bc_loaded", rd_data, 16'h3412);
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_bc", rd_data, 16'h0000);
      check("async_rst_sp", sp_out, 16'hFFFE);
      check("async_rst_pc", pc_out, 16'h0000);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Write visibility one cycle later
      wr_en = 2'b01; wr_sel = {4'd0, 4'd7}; wr_data = {8'h00, 8'h5A};
      rd_sel = {4'd0, 4'd7};
      #1;
      check("a_before_edge", {8'h00, rd_data[7:0]}, 16'h0000);
      cycle();
      rd_reg(4'd7, v);
      check("a_after_edge", {8'h00, v}, 16'h005A);

      // IDU wrap and LDH suppression
      pair_write(3'd2, 16'hFFFF);
      cycle();
      addr_sel = 3'd2; idu_en = 1'b1;
      cycle();
      addr_sel = 3'd2;
      #1;
      check("hl_wrap_inc", addr_out, 16'h0000);
      pair_write(3'd3, 16'h0000);
      cycle();
      addr_sel = 3'd3; idu_en = 1'b1; idu_dec = 1'b1;
      cycle();
      check("sp_wrap_dec", sp_out, 16'hFFFF);
      wr_en = 2'b01; wr_sel = {4'd0, 4'd1}; wr_data = {8'h00, 8'h10};
      cycle();
      addr_sel = 3'd7;
      #1;
      check("ldh_c_addr", addr_out, 16'hFF10);
      idu_en = 1'b1;
      cycle();
      rd_reg(4'd1, v);
      check("ldh_c_no_wb", {8'h00, v}, 16'h0010);

      // Port and pair write priority
      wr_en = 2'b11; wr_sel = {4'd4, 4'd4}; wr_data = {8'h22, 8'h11};
      pair_write(3'd2, 16'hABCD);
      cycle();
      addr_sel = 3'd2;
      #1;
      check("pair_beats_ports", addr_out, 16'hABCD);
      wr_en = 2'b11; wr_sel = {4'd4, 4'd4}; wr_data = {8'h22, 8'h11};
      cycle();
      addr_sel = 3'd2;
      #1;
      check("port1_beats_port0", addr_out, 16'h22CD);

      // WZ to AF copy beats flags, and F low nibble stays zero
      pair_write(3'd5, 16'h12FF);
      cycle();
      copy_op = 3'd1; flags_wr_en = 1'b1; flags_in = 4'h0;
      cycle();
      rd_sel = {4'd11, 4'd7};
      #1;
      check("copy_af", rd_data, 16'hF012);
      wr_en = 2'b01; wr_sel = {4'd0, 4'd11}; wr_data = {8'h00, 8'hFF};
      cycle();
      rd_reg(4'd11, v);
      check("f_low_nibble", {8'h00, v}, 16'h00F0);

      // PC: pair write beats IDU, then IDU alone
      pair_write(3'd4, 16'h0100);
      cycle();
      pair_write(3'd4, 16'h0150);
      addr_sel = 3'd4; idu_en = 1'b1;
      cycle();
      check("pc_pair_beats_idu", pc_out, 16'h0150);
      addr_sel = 3'd4; idu_en = 1'b1;
      cycle();
      check("pc_idu_inc", pc_out, 16'h0151);

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rst          = ($urandom_range(0, 49) == 0);
         if (rst) model_reset();
         wr_en        = 2'($urandom);
         wr_sel       = 8'($urandom);
         wr_data      = 16'($urandom);
         rd_sel       = 8'($urandom);
         addr_sel     = 3'($urandom);
         idu_en       = ($urandom_range(0, 2) == 0);
         idu_dec      = 1'($urandom);
         pair_wr_en   = ($urandom_range(0, 3) == 0);
         pair_wr_sel  = 3'($urandom);
         pair_wr_data = 16'($urandom);
         copy_op      = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
         flags_wr_en  = ($urandom_range(0, 2) == 0);
         flags_in     = 4'($urandom);
         push_expected();
         cycle();
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
